// File: rtl/cell_exercise_reader_if.sv
// Host/cell-bank bundle for the flop-cell exercise reader.
// Pure wiring, no latency.
// No backpressure: START is a single-cycle request, the readback is unthrottled.
interface cell_exercise_reader_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic             POL;
  logic [WIDTH-1:0] WDATA;
  logic [WIDTH-1:0] D_OUT;
  logic             CELL_CLK;
  logic [WIDTH-1:0] Q_IN;
  logic             SDO;
  logic             SVALID;
  logic             BUSY;
  logic             DONE;
  logic             MISMATCH;

  // Host / cell-bank side: issues requests, returns the cell Q outputs.
  modport master (
    output START, POL, WDATA, Q_IN,
    input  D_OUT, CELL_CLK, SDO, SVALID, BUSY, DONE, MISMATCH
  );

  // Reader side: drives the cells and the serial readback.
  modport slave (
    input  START, POL, WDATA, Q_IN,
    output D_OUT, CELL_CLK, SDO, SVALID, BUSY, DONE, MISMATCH
  );
endinterface

// File: rtl/cell_exercise_reader.sv
// Writes a word into a flop-cell bank with one clock pulse, samples Q, compares, shifts it out MSB first.
// DONE arrives 1+1+PULSE_LEN+SETTLE+1+WIDTH cycles after an accepted START.
// START is ignored while busy except in the DONE cycle; serial output is not throttled.
module cell_exercise_reader #(
  parameter int WIDTH     = 8,
  parameter int PULSE_LEN = 2,
  parameter int SETTLE    = 1
) (
  input logic                 CLK,
  input logic                 RST,
  cell_exercise_reader_if.slave bus
);

  // One counter serves every timed state, so size it for the longest one.
  localparam int MAXC  = (PULSE_LEN > SETTLE) ?
                         ((PULSE_LEN > WIDTH) ? PULSE_LEN : WIDTH) :
                         ((SETTLE > WIDTH) ? SETTLE : WIDTH);
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] PL_LAST = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] ST_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [CW-1:0] WD_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_SETTLE,
    S_SAMPLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             pol_q, pol_d;
  logic             mm_q, mm_d;

  // State and datapath registers; reset drops everything, including a partial frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      shreg_q <= '0;
      pol_q   <= 1'b0;
      mm_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      shreg_q <= shreg_d;
      pol_q   <= pol_d;
      mm_q    <= mm_d;
    end
  end

  // Next-state and datapath updates for the write/pulse/sample/shift sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    shreg_d = shreg_q;
    pol_d   = pol_q;
    mm_d    = mm_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // The DONE cycle also accepts START so transactions can run back to back.
        if (bus.START) begin
          dout_d  = bus.WDATA;
          pol_d   = bus.POL;
          state_d = S_SETUP;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == PL_LAST) begin
          cnt_d   = '0;
          state_d = (SETTLE == 0) ? S_SAMPLE : S_SETTLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == ST_LAST) begin
          cnt_d   = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SAMPLE: begin
        shreg_d = bus.Q_IN;
        mm_d    = (bus.Q_IN != dout_q);
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shreg_d = shreg_q << 1;
        if (cnt_q == WD_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs; the cell clock rests at the latched polarity and inverts only during the pulse.
  always_comb begin
    bus.D_OUT    = dout_q;
    bus.MISMATCH = mm_q;
    bus.CELL_CLK = (state_q == S_PULSE) ? ~pol_q : pol_q;
    bus.BUSY     = (state_q != S_IDLE);
    bus.SVALID   = (state_q == S_SHIFT);
    bus.SDO      = (state_q == S_SHIFT) & shreg_q[WIDTH-1];
    bus.DONE     = (state_q == S_DONE);
  end

endmodule
